spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 35 +++
 rtl/sync_ff.sv | 36 +++
 rtl/spi_slave_rx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Constants and types shared by the SPI slave receiver. Holds
//                the SPI mode, the byte width, the idle level used to reset
//                each input synchronizer, and the received-byte record.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE_0 = 2'd0,
        SPI_MODE_1 = 2'd1,
        SPI_MODE_2 = 2'd2,
        SPI_MODE_3 = 2'd3
    } spi_mode_e;

    // Receiver is built for mode 0: SCLK idles low, sample on the rising edge.
    localparam spi_mode_e   c_SPI_MODE  = SPI_MODE_0;
    localparam int unsigned c_BYTE_W    = 8;

    // Reset value of each input synchronizer, i.e. the bus idle level.
    localparam logic        c_SCLK_IDLE = 1'b0;
    localparam logic        c_CS_N_IDLE = 1'b1;
    localparam logic        c_MOSI_IDLE = 1'b0;
    localparam logic        c_DC_IDLE   = 1'b0;

    // One received byte together with its data/command flag.
    typedef struct packed {
        logic                dc;
        logic [c_BYTE_W-1:0] data;
    } spi_byte_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : Multi-flop synchronizer for one asynchronous input bit.
//                Resets to a per-instance value so the synchronized signal
//                starts from the bus idle level.
//  Ports       : clk_in   - system clock
//                rst_n_in - asynchronous active-low reset
//                d_in     - asynchronous input
//                q_out    - synchronized output (STAGES clocks of latency)
//  Revision    : 1.0  initial release
// ============================================================================
module sync_ff #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic d_in,
    output logic q_out
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_in};
        end
    end

    assign q_out = sync_q[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_rx
//  Description : Mode-0 SPI slave receiver, oversampled by clk_in. All bus
//                inputs are synchronized, SCLK/CS edges are detected in the
//                clk_in domain and bytes are assembled MSB first together
//                with the dc flag sampled on the byte's last SCLK edge.
//  Build macro : SPI_SLAVE_RX_FIFO_EN - when defined, completed bytes go into
//                a FIFO_DEPTH-entry FIFO with valid/ready handshake and a
//                sticky overrun flag; otherwise byte_valid_out is a one-cycle
//                pulse and the byte is held until the next one.
//  Ports       : clk_in, rst_n_in                   - clock, async reset
//                spi_sclk_in/mosi_in/cs_n_in, dc_in - asynchronous bus
//                byte_data_out/dc_out/valid_out     - received byte stream
//                byte_ready_in                      - consumer ready (FIFO)
//                frame_start_out/frame_end_out      - CS fall/rise pulses
//                overrun_out                        - sticky byte-loss flag
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                spi_sclk_in,
    input  logic                spi_mosi_in,
    input  logic                spi_cs_n_in,
    input  logic                dc_in,
    output logic [c_BYTE_W-1:0] byte_data_out,
    output logic                byte_dc_out,
    output logic                byte_valid_out,
    input  logic                byte_ready_in,
    output logic                frame_start_out,
    output logic                frame_end_out,
    output logic                overrun_out
);

    localparam int unsigned CNT_W = $clog2(c_BYTE_W);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic sclk_s;
    logic mosi_s;
    logic cs_n_s;
    logic dc_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(c_SCLK_IDLE)) u_sync_sclk (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (spi_sclk_in),
        .q_out    (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(c_MOSI_IDLE)) u_sync_mosi (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (spi_mosi_in),
        .q_out    (mosi_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(c_CS_N_IDLE)) u_sync_cs_n (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (spi_cs_n_in),
        .q_out    (cs_n_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(c_DC_IDLE)) u_sync_dc (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .d_in     (dc_in),
        .q_out    (dc_s)
    );

    // ------------------------------------------------------------------
    // Edge detection on the synchronized SCLK and CS
    // ------------------------------------------------------------------
    logic sclk_prev_q;
    logic cs_n_prev_q;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sample;
    logic w_cs_fall;
    logic w_cs_rise;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sclk_prev_q <= c_SCLK_IDLE;
            cs_n_prev_q <= c_CS_N_IDLE;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_n_prev_q <= cs_n_s;
        end
    end

    assign w_sclk_rise = sclk_s & ~sclk_prev_q;
    assign w_sclk_fall = ~sclk_s & sclk_prev_q;
    assign w_cs_fall   = ~cs_n_s & cs_n_prev_q;
    assign w_cs_rise   = cs_n_s & ~cs_n_prev_q;

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling.
    assign w_sample = ((c_SPI_MODE == SPI_MODE_0) || (c_SPI_MODE == SPI_MODE_3))
                      ? w_sclk_rise : w_sclk_fall;

    // ------------------------------------------------------------------
    // Byte assembly
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]    bit_cnt_q;
    logic [CNT_W-1:0]    bit_cnt_d;
    logic [c_BYTE_W-2:0] shift_q;
    logic [c_BYTE_W-2:0] shift_d;
    logic                done_q;
    logic                done_d;
    spi_byte_t           done_byte_q;
    spi_byte_t           done_byte_d;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        done_byte_d = done_byte_q;

        // Clearing on both CS edges drops any partial byte without a flag.
        if (w_cs_fall || w_cs_rise) begin
            bit_cnt_d = '0;
        end else if (w_sample && !cs_n_s) begin
            shift_d   = {shift_q[c_BYTE_W-3:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 1'b1;  // wraps to 0 after the last bit
            if (bit_cnt_q == CNT_W'(c_BYTE_W - 1)) begin
                done_d           = 1'b1;
                done_byte_d.data = {shift_q, mosi_s};
                done_byte_d.dc   = dc_s;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            done_byte_q <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            done_byte_q <= done_byte_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame pulses: registered once so they line up with done_q and the
    // byte of a frame is never reported after that frame's end pulse by
    // more than a single cycle.
    // ------------------------------------------------------------------
    logic frame_start_q;
    logic frame_end_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            frame_start_q <= w_cs_fall;
            frame_end_q   <= w_cs_rise;
        end
    end

    assign frame_start_out = frame_start_q;
    assign frame_end_out   = frame_end_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
    // ------------------------------------------------------------------
    // Output FIFO. Pointers carry one extra bit so full and empty are
    // distinguished by the level. Pop is evaluated before push so a full
    // FIFO accepts a new byte in the same cycle it delivers one.
    // ------------------------------------------------------------------
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    spi_byte_t        fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q;
    logic [PTR_W:0]   rd_ptr_q;
    logic [PTR_W:0]   w_level;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             overrun_q;

    assign w_level = wr_ptr_q - rd_ptr_q;
    assign w_empty = (w_level == '0);
    assign w_full  = (w_level == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop   = !w_empty && byte_ready_in;
    assign w_push  = done_q && (!w_full || w_pop);
    assign w_drop  = done_q && w_full && !w_pop;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else if (w_push) begin
            fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= done_byte_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // A loss in the same cycle as a new frame start is kept visible.
            if (w_drop) begin
                overrun_q <= 1'b1;
            end else if (w_cs_fall) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign byte_valid_out = !w_empty;
    assign byte_data_out  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]].data;
    assign byte_dc_out    = fifo_mem_q[rd_ptr_q[PTR_W-1:0]].dc;
    assign overrun_out    = overrun_q;
`else
    // ------------------------------------------------------------------
    // Direct output: one-cycle valid pulse, byte held until the next one.
    // The consumer cannot stall this path, so ready is not observed.
    // ------------------------------------------------------------------
    logic      valid_q;
    spi_byte_t out_byte_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q    <= 1'b0;
            out_byte_q <= '0;
        end else begin
            valid_q <= done_q;
            if (done_q) begin
                out_byte_q <= done_byte_q;
            end
        end
    end

    assign byte_valid_out = valid_q;
    assign byte_data_out  = out_byte_q.data;
    assign byte_dc_out    = out_byte_q.dc;
    assign overrun_out    = 1'b0;

    localparam int unsigned unused_fifo_depth = FIFO_DEPTH;
    logic unused_ready;
    assign unused_ready = byte_ready_in;
`endif

endmodule : spi_slave_rx
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_rx
//  Description : Self-checking bench for spi_slave_rx. Drives SPI frames
//                bit by bit and keeps a byte-level reference model: bits
//                accumulate MSB first, every eighth bit yields a byte with
//                the dc level of that bit, and a CS rise or reset discards
//                the remainder. Received bytes are collected by a monitor
//                and compared with the model after each frame.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_rx;

    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int HALF        = 5;   // SCLK half period in clk cycles

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       sclk   = 1'b0;
    logic       mosi   = 1'b0;
    logic       cs_n   = 1'b1;
    logic       dc     = 1'b0;
    logic       ready  = 1'b1;
    logic [7:0] data_o;
    logic       dc_o;
    logic       valid_o;
    logic       fs_o;
    logic       fe_o;
    logic       ovr_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    spi_slave_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .spi_sclk_in     (sclk),
        .spi_mosi_in     (mosi),
        .spi_cs_n_in     (cs_n),
        .dc_in           (dc),
        .byte_data_out   (data_o),
        .byte_dc_out     (dc_o),
        .byte_valid_out  (valid_o),
        .byte_ready_in   (ready),
        .frame_start_out (fs_o),
        .frame_end_out   (fe_o),
        .overrun_out     (ovr_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: collect accepted bytes and frame pulses on the falling edge
    // ------------------------------------------------------------------
    logic [8:0] got_q[$];
    int         got_cyc_q[$];
    int         fs_cnt = 0;
    int         fe_cnt = 0;
    int         fe_cyc = 0;
    logic       take;

`ifdef SPI_SLAVE_RX_FIFO_EN
    assign take = valid_o && ready;
`else
    assign take = valid_o;
`endif

    always @(negedge clk) begin
        if (take) begin
            got_q.push_back({dc_o, data_o});
            got_cyc_q.push_back(cyc);
        end
        if (fs_o) fs_cnt <= fs_cnt + 1;
        if (fe_o) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    logic [8:0] exp_q[$];
    int         m_n       = 0;
    int         m_acc     = 0;
    int         last_edge = 0;

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_out(input logic b, input logic d);
        mosi = b;
        dc   = d;
        clk_wait(HALF);
        sclk      = 1'b1;
        last_edge = cyc;
        m_acc     = (m_acc * 2 + int'(b)) % 256;
        m_n++;
        if (m_n == 8) begin
            exp_q.push_back({d, m_acc[7:0]});
            m_n = 0;
        end
        clk_wait(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        for (int i = 7; i >= 0; i--) bit_out(b[i], d);
    endtask

    task automatic cs_fall();
        cs_n = 1'b0;
        m_n  = 0;
        clk_wait(HALF);
    endtask

    task automatic cs_rise();
        clk_wait(HALF);
        cs_n = 1'b1;
        m_n  = 0;
        clk_wait(2 * HALF);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        clk_wait(SYNC_STAGES + 6);
        check({tag, ".count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int fs0;
        int fe0;
        int lat;
        int nbits;
        logic d;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        clk_wait(5);
        check("rst.data",  data_o,  0);
        check("rst.dc",    dc_o,    0);
        check("rst.valid", valid_o, 0);
        check("rst.fs",    fs_o,    0);
        check("rst.fe",    fe_o,    0);
        check("rst.ovr",   ovr_o,   0);
        rst_n = 1'b1;
        clk_wait(3);

        // ---------------- single byte 0xDA ----------------
        fs0 = fs_cnt;
        fe0 = fe_cnt;
        cs_fall();
        send_byte(8'hDA, 1'b0);
        cs_rise();
        lat = (got_cyc_q.size() > 0) ? got_cyc_q[0] - last_edge : -1;
        check("single.latency_ok",
              (lat == SYNC_STAGES + 2) || (lat == SYNC_STAGES + 3), 1);
        check("single.fs_pulses", fs_cnt - fs0, 1);
        check("single.fe_pulses", fe_cnt - fe0, 1);
        check("single.fe_after_byte",
              (got_cyc_q.size() > 0) && (fe_cyc + 1 >= got_cyc_q[0]), 1);
        check("single.value", (got_q.size() > 0) ? got_q[0] : 9'h1FF, 9'h0DA);
        compare_stream("single");

        // ---------------- partial byte, then 0xA5 ----------------
        fe0 = fe_cnt;
        cs_fall();
        for (int i = 0; i < 5; i++) bit_out(1'b1, 1'b0);
        cs_rise();
        check("partial.fe_pulse", fe_cnt - fe0, 1);
        compare_stream("partial");
        cs_fall();
        send_byte(8'hA5, 1'b0);
        cs_rise();
        compare_stream("after_partial");

        // ---------------- back-to-back 0x12, 0x34, dc=1 ----------------
        cs_fall();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        cs_rise();
        compare_stream("b2b");

        // ---------------- SCLK ignored while CS high ----------------
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            clk_wait(HALF);
            sclk = 1'b1;
            clk_wait(HALF);
            sclk = 1'b0;
        end
        compare_stream("cs_high_idle");
        cs_fall();
        send_byte(8'h3C, 1'b0);
        cs_rise();
        compare_stream("after_idle");

        // ---------------- random frames ----------------
        for (int f = 0; f < 6; f++) begin
            nbits = $urandom_range(26, 8);
            d     = 1'b0;
            cs_fall();
            for (int i = 0; i < nbits; i++) begin
                if (i % 8 == 0) d = 1'($urandom % 2);
                bit_out(1'($urandom % 2), d);
            end
            cs_rise();
            compare_stream($sformatf("rand%0d", f));
        end

        // ---------------- mid-byte reset ----------------
        cs_fall();
        for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0);
        rst_n = 1'b0;
        clk_wait(3);
        rst_n = 1'b1;
        m_n   = 0;
        cs_n  = 1'b1;
        clk_wait(2 * HALF + 5);
        compare_stream("mid_reset");
        cs_fall();
        send_byte(8'hFF, 1'b0);
        cs_rise();
        compare_stream("after_reset");

`ifdef SPI_SLAVE_RX_FIFO_EN
        // ---------------- FIFO overrun ----------------
        ready = 1'b0;
        cs_fall();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'($urandom % 2));
        cs_rise();
        check("ovr.flag_set", ovr_o, 1);
        check("ovr.valid_held", valid_o, 1);
        cs_n = 1'b0;
        clk_wait(SYNC_STAGES + 4);
        check("ovr.cleared_on_cs_fall", ovr_o, 0);
        cs_n = 1'b1;
        clk_wait(SYNC_STAGES + 4);
        void'(exp_q.pop_back());   // the fifth byte was lost
        ready = 1'b1;
        clk_wait(10);
        compare_stream("ovr.drain");
`else
        // ---------------- ready ignored, no overrun ----------------
        ready = 1'b0;
        cs_fall();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'($urandom % 2));
        cs_rise();
        check("noovr.flag", ovr_o, 0);
        compare_stream("noovr.bytes");
        ready = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spi_slave_rx
`default_nettype wire
